// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA timing types, FSM encoding and default 800x600 timing.
package vga_pkg;
    localparam int COORD_W = 16;
    localparam int SYNC_H = 0;
    localparam int SYNC_V = 1;
    localparam int SYNC_B = 2;
    localparam int H_ACTIVE = 800;
    localparam int H_FRONT = 40;
    localparam int H_SYNC = 128;
    localparam int H_BACK = 88;
    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_ACTIVE = 600;
    localparam int V_FRONT = 1;
    localparam int V_SYNC = 4;
    localparam int V_BACK = 23;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} vga_state_t;
    typedef struct packed {
        logic [COORD_W-1:0] h;
        logic [COORD_W-1:0] ha;
        logic [COORD_W-1:0] v;
        logic [COORD_W-1:0] va;
    } timing_t;
endpackage

// File: rtl/vga_sync_edge_detect.sv
// vga_sync_edge_detect: polarity-normalised two-stage input pipeline with leading-edge pulses.
module vga_sync_edge_detect
    import vga_pkg::*;
#(
    parameter bit sync_active_high = 1'b1
) (
    input  logic       pixel_clock,
    input  logic       reset_n,
    input  logic       hsync,
    input  logic       vsync,
    input  logic       blank,
    output logic       active,
    output logic [2:0] rise
);
    logic [2:0] s1, s2;
    always_ff @(posedge pixel_clock or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1[SYNC_H] <= hsync ^ ~sync_active_high;
            s1[SYNC_V] <= vsync ^ ~sync_active_high;
            s1[SYNC_B] <= blank;
            s2 <= s1;
        end
    end
    assign active = s1[SYNC_B];
    assign rise = s1 & ~s2;
endmodule

// File: rtl/vga_timing_recovery.sv
// vga_timing_recovery: recovers pixel x/y from an external hsync/vsync/blank stream
// and locks onto its line/frame timing after several identical frames.
module vga_timing_recovery
    import vga_pkg::*;
#(
    parameter int lock_frames = 3,
    parameter int max_h_period = 4095,
    parameter bit sync_active_high = 1'b1
) (
    input  logic               pixel_clock,
    input  logic               reset_n,
    input  logic               hsync,
    input  logic               vsync,
    input  logic               blank,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               xy_in_active,
    output logic               frame_start,
    output logic [COORD_W-1:0] h_total,
    output logic [COORD_W-1:0] h_active,
    output logic [COORD_W-1:0] v_total,
    output logic [COORD_W-1:0] v_active,
    output logic               locked,
    output logic               error
);
    localparam logic [COORD_W-1:0] HMAX = COORD_W'(max_h_period);
    localparam logic [COORD_W-1:0] ONE = 1;
    localparam logic [COORD_W-1:0] SAT = '1;
    localparam logic [3:0] LOCK_LAST = 4'(lock_frames - 1);

    logic active, h_edge, v_edge, b_edge;
    logic [2:0] rise;
    vga_state_t state;
    logic [COORD_W-1:0] hcnt, acnt, line_period;
    timing_t acc, acc_n, ref_t, lk;
    logic bad, bad_n, h_seen, ref_valid, y_first;
    logic same, lock_now, h_fault, tmo;
    logic [3:0] match_cnt, match_n;

    vga_sync_edge_detect #(.sync_active_high(sync_active_high)) u_edge (
        .pixel_clock(pixel_clock),
        .reset_n(reset_n),
        .hsync(hsync),
        .vsync(vsync),
        .blank(blank),
        .active(active),
        .rise(rise)
    );
    assign h_edge = rise[SYNC_H];
    assign v_edge = rise[SYNC_V];
    assign b_edge = rise[SYNC_B];
    assign {h_total, h_active, v_total, v_active} = lk;

    // Frame accumulators as they stand once the current line (if closing) is folded in,
    // so a coincident vsync edge closes the frame with that line included.
    always_comb begin
        line_period = hcnt + ONE;
        acc_n = acc;
        bad_n = bad;
        if (h_edge) begin
            acc_n.h = h_seen ? acc.h : line_period;
            bad_n = bad | (h_seen && line_period != acc.h);
            acc_n.ha = (acnt > acc.ha) ? acnt : acc.ha;
            acc_n.v = acc.v + ONE;
            acc_n.va = acc.va + COORD_W'(acnt != '0);
        end
        same = ref_valid && acc_n == ref_t && !bad_n;
        match_n = same ? match_cnt + 4'd1 : 4'd0;
        lock_now = match_n == LOCK_LAST && !bad_n;
        h_fault = h_edge && line_period != lk.h;
        tmo = !h_edge && !v_edge && hcnt == HMAX - ONE;
    end

    always_ff @(posedge pixel_clock or negedge reset_n) begin
        if (!reset_n) begin
            hcnt <= '0;
            acnt <= '0;
            acc <= '0;
            bad <= 1'b0;
            h_seen <= 1'b0;
        end else begin
            hcnt <= h_edge ? '0 : (hcnt == HMAX ? hcnt : hcnt + ONE);
            acnt <= h_edge ? COORD_W'(active) : (active && acnt != SAT ? acnt + ONE : acnt);
            acc <= v_edge ? '0 : acc_n;
            bad <= v_edge ? 1'b0 : bad_n;
            h_seen <= !v_edge && (h_seen || h_edge);
        end
    end

    always_ff @(posedge pixel_clock or negedge reset_n) begin
        if (!reset_n) begin
            x <= '0;
            y <= '0;
            y_first <= 1'b0;
            xy_in_active <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= v_edge;
            xy_in_active <= active && state == LOCKED;
            x <= b_edge ? '0 : (active && x != SAT ? x + ONE : x);
            y <= !b_edge ? y : ((y_first || v_edge) ? '0 : (y == SAT ? y : y + ONE));
            y_first <= (y_first || v_edge) && !b_edge;
        end
    end

    always_ff @(posedge pixel_clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= SEARCH;
            match_cnt <= '0;
            ref_valid <= 1'b0;
            ref_t <= '0;
            lk <= '0;
            locked <= 1'b0;
            error <= 1'b0;
        end else begin
            error <= 1'b0;
            case (state)
                SEARCH: begin
                    if (v_edge) begin
                        state <= MEASURE;
                        match_cnt <= '0;
                        ref_valid <= 1'b0;
                    end else if (tmo) begin
                        error <= 1'b1;
                    end
                end
                MEASURE: begin
                    if (v_edge) begin
                        match_cnt <= match_n;
                        if (!same) begin
                            ref_t <= acc_n;
                            ref_valid <= !bad_n;
                        end
                        if (lock_now) begin
                            state <= LOCKED;
                            lk <= acc_n;
                            locked <= 1'b1;
                        end
                    end else if (tmo) begin
                        state <= SEARCH;
                        error <= 1'b1;
                    end
                end
                default: begin
                    if (h_fault || (v_edge && (acc_n != lk || bad_n)) || tmo) begin
                        state <= SEARCH;
                        locked <= 1'b0;
                        error <= 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_vga_timing_recovery.sv
// tb_vga_timing_recovery: directed stimulus on a reduced 20x12 raster with hand-computed expectations.
module tb_vga_timing_recovery;
    import vga_pkg::*;

    logic pixel_clock = 1'b0;
    logic reset_n, hsync, vsync, blank;
    logic [15:0] x, y, h_total, h_active, v_total, v_active;
    logic xy_in_active, frame_start, locked, error;
    logic [15:0] nx, ny, nh_total, nh_active, nv_total, nv_active;
    logic n_xy_in_active, n_frame_start, n_locked, n_error;

    int n_checks = 0, n_fail = 0;
    int cyc = 0, last_fs = -1, fs_seen = 0, err_cnt = 0, d1 = -1, d2 = -1;
    bit probe = 1'b0, fs_chk = 1'b0;

    always #5 pixel_clock = ~pixel_clock;

    vga_timing_recovery #(.lock_frames(3), .max_h_period(4095), .sync_active_high(1'b1)) dut (
        .pixel_clock(pixel_clock), .reset_n(reset_n),
        .hsync(hsync), .vsync(vsync), .blank(blank),
        .x(x), .y(y), .xy_in_active(xy_in_active), .frame_start(frame_start),
        .h_total(h_total), .h_active(h_active), .v_total(v_total), .v_active(v_active),
        .locked(locked), .error(error)
    );

    vga_timing_recovery #(.lock_frames(3), .max_h_period(4095), .sync_active_high(1'b0)) dut_n (
        .pixel_clock(pixel_clock), .reset_n(reset_n),
        .hsync(~hsync), .vsync(~vsync), .blank(blank),
        .x(nx), .y(ny), .xy_in_active(n_xy_in_active), .frame_start(n_frame_start),
        .h_total(nh_total), .h_active(nh_active), .v_total(nv_total), .v_active(nv_active),
        .locked(n_locked), .error(n_error)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // One pixel clock: sample outputs for the pixel driven two iterations ago, then drive the next one.
    task automatic step(input logic hs, input logic vs, input logic bl, input int tag);
        @(negedge pixel_clock);
        cyc++;
        if (error) err_cnt++;
        if (frame_start && fs_chk) begin
            fs_seen++;
            if (last_fs >= 0) check("frame_start_period", cyc - last_fs, 240);
            last_fs = cyc;
        end
        if (probe && d2 == 203) begin
            check("probe_x", 32'(x), 3);
            check("probe_y", 32'(y), 2);
            check("probe_active", 32'(xy_in_active), 1);
        end
        if (probe && d2 == 507) begin
            check("last_x", 32'(x), 7);
            check("last_y", 32'(y), 5);
            check("last_active", 32'(xy_in_active), 1);
        end
        if (probe && d2 == 508) check("after_last_active", 32'(xy_in_active), 0);
        d2 = d1;
        d1 = tag;
        hsync = hs;
        vsync = vs;
        blank = bl;
    endtask

    // 20 clocks/line (8 active, hsync at 10..12), 12 lines/frame (6 active, vsync on lines 8..9).
    task automatic run_frame(input int short_line, input int nlines);
        for (int l = 0; l < nlines; l++)
            for (int c = 0; c < ((l == short_line) ? 19 : 20); c++)
                step(c >= 10 && c < 13, l >= 8 && l < 10, l < 6 && c < 8, l * 100 + c);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, -1);
    endtask

    task automatic check_timing(input string tag);
        check({tag, "_h_total"}, 32'(h_total), 20);
        check({tag, "_h_active"}, 32'(h_active), 8);
        check({tag, "_v_total"}, 32'(v_total), 12);
        check({tag, "_v_active"}, 32'(v_active), 6);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0;
        hsync = 1'b0;
        vsync = 1'b0;
        blank = 1'b0;
        repeat (3) @(negedge pixel_clock);
        check("rst_locked", 32'(locked), 0);
        check("rst_h_total", 32'(h_total), 0);
        check("rst_x", 32'(x), 0);
        check("rst_error", 32'(error), 0);
        check("rst_xy_active", 32'(xy_in_active), 0);
        reset_n = 1'b1;

        fs_chk = 1'b1;
        for (int f = 1; f <= 5; f++) begin
            probe = (f == 5);
            run_frame(-1, 12);
            if (f == 3) check("lock_not_before_f4", 32'(locked), 0);
            if (f == 4) begin
                check("lock_in_f4", 32'(locked), 1);
                check_timing("lock");
                check("inv_locked", 32'(n_locked), 1);
                check("inv_h_total", 32'(nh_total), 20);
                check("inv_h_active", 32'(nh_active), 8);
                check("inv_v_total", 32'(nv_total), 12);
                check("inv_v_active", 32'(nv_active), 6);
            end
        end
        probe = 1'b0;
        fs_chk = 1'b0;
        check("frame_start_count", fs_seen, 5);
        check("no_error_clean", err_cnt, 0);

        err_cnt = 0;
        run_frame(2, 12);
        check("short_line_error", err_cnt, 1);
        check("short_line_unlock", 32'(locked), 0);
        run_frame(-1, 12);
        run_frame(-1, 12);
        check("relock_not_early", 32'(locked), 0);
        run_frame(-1, 12);
        check("relock", 32'(locked), 1);
        check_timing("relock");

        err_cnt = 0;
        idle(4000);
        check("tmo_not_early", err_cnt, 0);
        idle(200);
        check("tmo_error", err_cnt, 1);
        check("tmo_unlock", 32'(locked), 0);
        check("tmo_state", 32'(dut.state), 32'(SEARCH));
        idle(4200);
        check("tmo_once", err_cnt, 1);

        for (int f = 1; f <= 4; f++) run_frame(-1, 12);
        check("pre_reset_locked", 32'(locked), 1);
        run_frame(-1, 3);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_locked", 32'(locked), 0);
        check("async_rst_h_total", 32'(h_total), 0);
        check("async_rst_v_active", 32'(v_active), 0);
        check("async_rst_x", 32'(x), 0);
        check("async_rst_y", 32'(y), 0);
        repeat (2) @(posedge pixel_clock);
        #2 reset_n = 1'b1;
        for (int f = 1; f <= 4; f++) begin
            run_frame(-1, 12);
            if (f == 3) check("post_rst_not_early", 32'(locked), 0);
        end
        check("post_rst_lock", 32'(locked), 1);
        check_timing("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/vga_timing_recovery.md
Name: vga_timing_recovery

Overview:
- Receive-side counterpart of the VGA location generator: consumes hsync/vsync/blank on the pixel clock and recovers pixel x/y plus the frame timing.
- Measures h_total, h_active, v_total and v_active, and declares lock after N consecutive identical frames.
- Used for loopback self-check of the video output and for capture/overlay logic that needs coordinates from an external sync stream.

Parameters:
- lock_frames, 3, consecutive matching frames required to assert locked (1..15).
- max_h_period, 4095, clocks without an hsync rising edge before a timeout error.
- sync_active_high, 1, polarity of hsync/vsync (1 = pulse is high).

Ports:
- pixel_clock  in  1  sole clock; all logic on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- hsync  in  1  horizontal sync, polarity per sync_active_high.
- vsync  in  1  vertical sync, polarity per sync_active_high.
- blank  in  1  high during active video (1 = visible pixel).
- x  out  16  active-pixel column, 0-based.
- y  out  16  active-line row, 0-based.
- xy_in_active  out  1  x/y name a visible pixel this cycle.
- frame_start  out  1  one-cycle pulse on each detected vsync leading edge.
- h_total  out  16  locked clocks per line.
- h_active  out  16  locked active pixels per line.
- v_total  out  16  locked lines per frame.
- v_active  out  16  locked active lines per frame.
- locked  out  1  timing stable.
- error  out  1  one-cycle pulse on lock loss or timeout.

Behaviour:
- Reset (async assert, sync release): all outputs 0; all counters 0; FSM in SEARCH; input pipeline cleared to the inactive level.
- Input pipeline:
  - s1 = inputs registered, with sync polarity normalised so 1 = pulse.
  - s2 = s1 delayed one cycle.
  - A leading edge is s1 & ~s2.
  - x/y/xy_in_active/frame_start are registered from s1/s2, so they reflect the input sampled 2 clocks earlier. Latency is fixed at 2.
- x:
  - Loads 0 on a blank rising edge.
  - Increments on each further active cycle.
  - Holds while inactive.
  - Saturates at 16'hFFFF.
- y:
  - Loads 0 on the first blank rising edge after a vsync edge.
  - Increments on each later blank rising edge in the same frame.
  - Holds otherwise; saturates.
- xy_in_active = delayed blank. It is forced to 0 outside LOCKED.
- Measurement counters:
  - hcnt counts clocks since the last hsync edge. At each hsync edge, line_period = hcnt + 1 and hcnt clears.
  - The first line_period of a frame is latched as frame_h. Any differing line_period in the same frame sets frame_bad.
  - Active pixels per line are counted. The maximum over the frame gives frame_ha.
  - hsync edges since the last vsync edge give frame_v.
  - Lines containing any active pixel give frame_va.
- Frame close: on each vsync edge, the frame tuple is (frame_h, frame_ha, frame_v, frame_va, frame_bad). Per-frame accumulators then clear.
- FSM:
  - SEARCH: on a vsync edge, go to MEASURE with match_cnt = 0. The first partial frame is discarded.
  - MEASURE: on each vsync edge, compare the tuple with the previous one.
    - Equal and frame_bad = 0: match_cnt++.
    - Otherwise: match_cnt = 0 and the new tuple becomes the reference.
    - When match_cnt reaches lock_frames - 1: go to LOCKED. h_total/h_active/v_total/v_active load from the tuple and locked = 1 on the following cycle.
  - LOCKED:
    - Any line_period != h_total, or a frame tuple != the locked values: go to SEARCH, locked = 0, error pulses 1 cycle.
    - Timing outputs hold their last locked values until the next lock.
- Timeout: hcnt reaching max_h_period in any state pulses error, goes to SEARCH, clears locked, and saturates hcnt until the next hsync edge. This applies in SEARCH too, so a dead input pulses error once per timeout and not again until an hsync arrives.
- Simultaneous hsync and vsync edges: close the line first, then the frame. That line counts in the closing frame.
- Simultaneous timeout and edge: the edge wins.

Decomposition:
- Shared package vga_pkg:
  - FSM state encoding (SEARCH, MEASURE, LOCKED).
  - 16-bit coordinate width constant.
  - Default 800x600 timing constants, shared with the generator.
- One sub-module: vga_sync_edge_detect. It does the polarity normalise, the 2-stage register and the leading-edge pulses for hsync/vsync/blank, instantiated once.

Test Plan:
- Reduced timing (h_total 20, h_active 8, v_total 12, v_active 6, lock_frames 3), 5 frames:
  - locked rises during frame 4.
  - h_total=20, h_active=8, v_total=12, v_active=6.
  - frame_start every 240 clocks.
- Locked stream, probe the pixel sampled at column 3, row 2 → 2 clocks later x=3, y=2, xy_in_active=1; the last active pixel gives x=7, y=5.
- Locked, one line shortened to 19 clocks → error pulse 1 cycle, locked=0. Relock occurs 3 full frames later with the same values.
- hsync held low for max_h_period clocks (4095) → error pulses exactly once, locked=0, FSM in SEARCH.
- reset_n asserted mid-frame while locked → all outputs 0 immediately (asynchronous). After release, no lock before 3 full clean frames.
- sync_active_high=0 with inverted sync stimulus → identical lock and measured values to scenario 1.
